cla_pipe_addsub: RTL
====================

# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor built from 16-bit CLA slices. Each slice uses 4-bit block lookahead, with a second-level lookahead across the four blocks in the slice. One slice is evaluated per pipeline stage, with a registered carry passed between stages. Each result carries flags. A valid/ready handshake with full back-pressure lets it sit between datapath stages as the next-generation adder for wide operands.

## Interface
- WIDTH, 32: operand width; must be a multiple of 16, minimum 16. N = WIDTH/16 slices and stages.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block accepts operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in; used only when sub=0
- sub  in  1  0: A+B+cin; 1: A−B (A + ~B + 1)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  carry out of bit WIDTH−1; for sub, 1 means no borrow
- ovf  out  1  two's-complement signed overflow
- zero  out  1  sum == 0

## Operation
- Effective operand: B' = sub ? ~b : b. Effective carry-in: c0 = sub ? 1 : cin.
- Slice k covers bits [16k+15:16k]:
  - p = a ^ B', g = a & B' per bit.
  - Four 4-bit blocks each produce internal carries plus block ps/gs.
  - Block carry: c_out = gs | (ps & c_in).
  - sum bit = p ^ carry.
- Stage k computes slice k from its skewed operands and the carry registered by stage k−1. Stage 0 uses c0.
- Operand skew: slice k's a/B' bits travel through k register stages before use.
- Result deskew: the sum slice from stage k is held through N−1−k further stages, so all slices of one operation leave together.
- ovf = carry into MSB XOR carry out of MSB, computed in the last stage. zero is computed from the full assembled sum in the last stage.
- Sequencing: each stage holds a valid bit. Global advance enable is en = !out_valid | out_ready.
  - On en, all stages shift one position.
  - When en=0, every register holds its value. No data is dropped or duplicated.
- in_ready = en, combinational from out_valid/out_ready. A transfer happens when in_valid & in_ready.
- Bubbles propagate: stage valid bits follow in_valid & in_ready into stage 0.
- Reset (asynchronous assert, synchronous deassert is external):
  - All valid bits, carry registers, and data registers clear to 0.
  - out_valid=0, sum=0, cout=0, ovf=0, zero=0.
  - in_ready=1 after reset.
- Reset mid-operation discards all in-flight results. No output pulse appears after reset release until new operands are accepted.

## Timing
- Latency: N cycles from accept edge to out_valid (WIDTH=32: 2 cycles; WIDTH=16: 1 cycle).
- Throughput: one operation per cycle while out_ready=1.
- Critical path per stage: one 16-bit slice (pg → block lookahead → 4-block carry chain → sum XOR), independent of WIDTH.
- out_valid & !out_ready: sum/cout/ovf/zero stay stable until the handshake completes.
- Simultaneous out-accept and in-accept with the pipeline full is permitted; the pipeline stays full.
- cin and sub are sampled only on accept. Changes while in_ready=0 have no effect.

## Test plan
- WIDTH=32, out_ready=1:
  - a=0x0000FFFF, b=0x00000001, sub=0, cin=0 → 2 cycles later sum=0x00010000, cout=0, ovf=0, zero=0.
  - This exercises the inter-stage carry.
- a=0xFFFFFFFF, b=0x00000001, sub=0, cin=0 → sum=0x00000000, cout=1, ovf=0, zero=1.
- a=0x7FFFFFFF, b=0, sub=0, cin=1 → sum=0x80000000, cout=0, ovf=1.
- Subtraction:
  - a=5, b=7, sub=1, cin=1 (cin ignored) → sum=0xFFFFFFFE, cout=0, ovf=0.
  - Then a=0x80000000, b=1, sub=1 → sum=0x7FFFFFFF, cout=1, ovf=1.
- Back-pressure:
  - Stream 4 back-to-back adds (i+i for i=1..4) while out_ready is held 0 for cycles 3–6.
  - Required: in_ready=0 while full; outputs stable while stalled.
  - Results 2, 4, 6, 8 emerge in order with no loss or duplication.
- Reset mid-flight: assert rst_n=0 with 2 operations in flight.
  - Required: immediately out_valid=0 and all outputs 0.
  - After release: no output until a new accept; then a correct result follows N cycles later.
  - Repeat the whole bench at WIDTH=16 (latency 1) and WIDTH=64 (latency 4, carry chain 0xFFFF_FFFF_FFFF_FFFF+1 → 0, cout=1).

Source files
------------

// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub
//
// Pipelined carry-lookahead adder/subtractor for wide operands. The operand
// is cut into 16-bit slices; stage k evaluates slice k with a two-level
// lookahead adder (4-bit blocks, then lookahead across the four blocks) using
// the carry registered by stage k-1. Upper-slice operands are skewed forward
// through registers until their stage is reached, and finished lower sum
// slices are held back so that every slice of one operation leaves together.
// A single global advance enable gives full back-pressure.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid
//   in_ready   operands accepted this cycle (combinational from out side)
//   a, b       operands, WIDTH bits
//   cin        carry-in, used only for addition
//   sub        0: a + b + cin, 1: a - b
//   out_valid  result valid
//   out_ready  downstream accepts result
//   sum        result modulo 2^WIDTH
//   cout       carry out of the MSB (for subtraction 1 means no borrow)
//   ovf        two's-complement signed overflow
//   zero       sum == 0
//
// WIDTH must be a multiple of 16 and at least 16.

module cla_pipe_addsub #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N = WIDTH / 16;

    // 16-bit two-level carry-lookahead slice. Returns {carry_out, sum[15:0]}.
    function automatic logic [16:0] cla16(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic        ci);
        logic [15:0] p;
        logic [15:0] g;
        logic [15:0] c;
        logic [3:0]  bp;
        logic [3:0]  bg;
        logic [4:0]  bc;
        p = x ^ y;
        g = x & y;
        for (int i = 0; i < 4; i++) begin
            bp[i] = &p[4*i +: 4];
            bg[i] = g[4*i+3]
                  | (p[4*i+3] & g[4*i+2])
                  | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                  | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
        end
        // Second level: each block carry is gs | ps & c_in, expanded so that
        // no block carry waits on the one below it.
        bc[0] = ci;
        bc[1] = bg[0] | (bp[0] & ci);
        bc[2] = bg[1] | (bp[1] & bg[0]) | (bp[1] & bp[0] & ci);
        bc[3] = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0])
              | (bp[2] & bp[1] & bp[0] & ci);
        bc[4] = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1])
              | (bp[3] & bp[2] & bp[1] & bg[0])
              | (bp[3] & bp[2] & bp[1] & bp[0] & ci);
        for (int i = 0; i < 4; i++) begin
            c[4*i]   = bc[i];
            c[4*i+1] = g[4*i] | (p[4*i] & bc[i]);
            c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & bc[i]);
            c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1])
                     | (p[4*i+2] & p[4*i+1] & g[4*i])
                     | (p[4*i+2] & p[4*i+1] & p[4*i] & bc[i]);
        end
        return {bc[4], p ^ c};
    endfunction

    logic             en;
    logic [N-1:0]     vld;
    logic [N-1:0]     load;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic             ovf_next;
    logic             ovf_q;
    logic             zero_q;
    wire  [N-1:0]     carry;
    wire  [WIDTH-1:0] sum_next;
    wire  [WIDTH-1:0] sum_all;

    assign en        = !vld[N-1] | out_ready;
    assign in_ready  = en;
    assign out_valid = vld[N-1];
    assign sum       = sum_all;
    assign cout      = carry[N-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    // Subtraction folds into addition of ~b with a forced carry-in. load[k]
    // is the write enable for the registers at the output of stage k: they
    // only capture when the whole pipe advances and a real operation is
    // arriving, so bubbles leave the data registers untouched.
    always_comb begin
        b_eff   = sub ? ~b : b;
        c0      = sub | cin;
        load    = '0;
        load[0] = en & in_valid;
        for (int k = 1; k < N; k++) begin
            load[k] = en & vld[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else if (en) begin
            vld[0] <= in_valid;
            for (int k = 1; k < N; k++) begin
                vld[k] <= vld[k-1];
            end
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_slice
        logic [15:0] x;
        logic [15:0] y;
        logic        ci;
        logic [16:0] res;
        logic        c_q;
        logic [15:0] s_pipe [N-j];

        if (j == 0) begin : g_first
            assign x  = a[15:0];
            assign y  = b_eff[15:0];
            assign ci = c0;
        end else begin : g_skew
            // Operand bits for slice j ride along with the operation until
            // stage j picks them up.
            logic [15:0] a_pipe [j];
            logic [15:0] b_pipe [j];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int d = 0; d < j; d++) begin
                        a_pipe[d] <= '0;
                        b_pipe[d] <= '0;
                    end
                end else begin
                    if (load[0]) begin
                        a_pipe[0] <= a[16*j +: 16];
                        b_pipe[0] <= b_eff[16*j +: 16];
                    end
                    for (int d = 1; d < j; d++) begin
                        if (load[d]) begin
                            a_pipe[d] <= a_pipe[d-1];
                            b_pipe[d] <= b_pipe[d-1];
                        end
                    end
                end
            end

            assign x  = a_pipe[j-1];
            assign y  = b_pipe[j-1];
            assign ci = carry[j-1];
        end

        assign res = cla16(x, y, ci);

        // s_pipe[0] is the slice result produced by stage j; the following
        // entries delay it until the last stage so all slices line up.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                c_q <= 1'b0;
                for (int d = 0; d < N - j; d++) begin
                    s_pipe[d] <= '0;
                end
            end else begin
                if (load[j]) begin
                    c_q       <= res[16];
                    s_pipe[0] <= res[15:0];
                end
                for (int d = 1; d < N - j; d++) begin
                    if (load[j+d]) begin
                        s_pipe[d] <= s_pipe[d-1];
                    end
                end
            end
        end

        assign carry[j]            = c_q;
        assign sum_all[16*j +: 16] = s_pipe[N-1-j];

        if (j == N - 1) begin : g_last
            assign sum_next[16*j +: 16] = res[15:0];
            // Carry into the MSB is recovered as p[15] ^ sum[15].
            assign ovf_next = res[16] ^ res[15] ^ x[15] ^ y[15];
        end else begin : g_held
            assign sum_next[16*j +: 16] = s_pipe[N-2-j];
        end
    end

    // Flags are registered alongside the final sum so they change together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (load[N-1]) begin
            ovf_q  <= ovf_next;
            zero_q <= (sum_next == '0);
        end
    end

endmodule
